// File: rtl/color_detect_if.sv
// color_detect_if
//   Bundles the scan-control handshake, the frame-buffer read port and the
//   result bus of the colour detector.
//   slave  : the detector's view (drives address, status and results)
//   master : the surrounding system (drives start and read data)
//   Signals: start, rd_addr[AW], rd_data[8], busy, done, color[2],
//            cnt_r/cnt_g/cnt_b[AW]
`timescale 1ns/1ps
interface color_detect_if #(
    parameter int AW = 15
);
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;
    logic [1:0]    color;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_g;
    logic [AW-1:0] cnt_b;

    modport slave (
        input  start, rd_data,
        output rd_addr, busy, done, color, cnt_r, cnt_g, cnt_b
    );

    modport master (
        output start, rd_data,
        input  rd_addr, busy, done, color, cnt_r, cnt_g, cnt_b
    );
endinterface

// File: rtl/color_detect.sv
// color_detect
//   Scans an RGB332 frame buffer through its synchronous read port, one pixel
//   per clock, classifies each pixel as red / green / blue / other, and at the
//   end of the frame publishes the per-class counts and the dominant colour.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-low reset
//     bus  - color_detect_if.slave: start, rd_addr, rd_data, busy, done,
//            color (00 none, 01 red, 10 green, 11 blue), cnt_r/g/b
`timescale 1ns/1ps
module color_detect #(
    parameter int AW      = 15,
    parameter int NPIX    = 19200,
    parameter int MIN_CNT = 64
) (
    input  logic          clk,
    input  logic          rst,
    color_detect_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FLUSH  = 2'd2,
        DECIDE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    state_t        state;
    state_t        state_nxt;

    // High when rd_data carries a pixel of the current frame: the buffer
    // registered a valid scan address on the previous edge.
    logic          data_vld;

    logic [AW-1:0] acc_r;
    logic [AW-1:0] acc_g;
    logic [AW-1:0] acc_b;

    logic [2:0]    pix_r;
    logic [2:0]    pix_g;
    logic [1:0]    pix_b;
    logic          is_red;
    logic          is_green;
    logic          is_blue;

    logic [AW-1:0] win_cnt;
    logic [1:0]    win_color;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nxt is given a default before the case so that every
    // path assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SCAN;
            SCAN:    if (bus.rd_addr == LAST_ADDR) state_nxt = FLUSH;
            FLUSH:   state_nxt = DECIDE;
            DECIDE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Pixel classification; the three classes are disjoint.
    // ------------------------------------------------------------------
    assign pix_r    = bus.rd_data[7:5];
    assign pix_g    = bus.rd_data[4:2];
    assign pix_b    = bus.rd_data[1:0];
    assign is_red   = (pix_r >= 3'd5) && (pix_g <= 3'd2) && (pix_b <= 2'd1);
    assign is_green = (pix_g >= 3'd5) && (pix_r <= 3'd2) && (pix_b <= 2'd1);
    assign is_blue  = (pix_b == 2'd3) && (pix_r <= 3'd2) && (pix_g <= 3'd2);

    // ------------------------------------------------------------------
    // Dominant colour: strict compares keep the earlier class on a tie,
    // giving red > green > blue priority.
    // ------------------------------------------------------------------
    always_comb begin
        win_color = 2'b01;
        win_cnt   = acc_r;
        if (acc_g > win_cnt) begin
            win_color = 2'b10;
            win_cnt   = acc_g;
        end
        if (acc_b > win_cnt) begin
            win_color = 2'b11;
            win_cnt   = acc_b;
        end
    end

    // ------------------------------------------------------------------
    // Address generation, counting and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_addr <= '0;
            data_vld    <= 1'b0;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
            bus.done    <= 1'b0;
            bus.color   <= 2'b00;
            bus.cnt_r   <= '0;
            bus.cnt_g   <= '0;
            bus.cnt_b   <= '0;
        end else begin
            bus.done <= 1'b0;
            data_vld <= (state == SCAN);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.rd_addr <= '0;
                        acc_r       <= '0;
                        acc_g       <= '0;
                        acc_b       <= '0;
                    end
                end
                SCAN: begin
                    // Hold at the last pixel rather than wrapping into
                    // unwritten buffer space.
                    if (bus.rd_addr != LAST_ADDR)
                        bus.rd_addr <= bus.rd_addr + 1'b1;
                end
                DECIDE: begin
                    bus.cnt_r <= acc_r;
                    bus.cnt_g <= acc_g;
                    bus.cnt_b <= acc_b;
                    bus.color <= (32'(win_cnt) < 32'(MIN_CNT)) ? 2'b00 : win_color;
                    bus.done  <= 1'b1;
                end
                default: ;
            endcase

            // data_vld is never set in IDLE, so this cannot collide with
            // the clear on start acceptance.
            if (data_vld) begin
                if (is_red)   acc_r <= acc_r + 1'b1;
                if (is_green) acc_g <= acc_g + 1'b1;
                if (is_blue)  acc_b <= acc_b + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_color_detect.sv
// tb_color_detect
//   Bench for color_detect. Two instances: a 16-pixel frame (MIN_CNT=2) for
//   directed and random frames, and a full 19200-pixel frame (MIN_CNT=64)
//   for the threshold cases. Expected results come from a frame-level model
//   and are queued at start; a monitor per instance compares on done.
`timescale 1ns/1ps
module tb_color_detect;

    localparam int AW     = 15;
    localparam int NPIX_S = 16;
    localparam int MIN_S  = 2;
    localparam int NPIX_L = 19200;
    localparam int MIN_L  = 64;

    typedef logic [7:0] pix_q_t [$];
    typedef struct {
        int         r;
        int         g;
        int         b;
        logic [1:0] color;
        longint     done_cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_s;
    logic   rst_l;
    longint cyc = 0;

    int checks = 0;
    int errors = 0;

    exp_t   sb_s[$];
    exp_t   sb_l[$];
    exp_t   mon_e_s;
    exp_t   mon_e_l;

    logic [7:0]    mem_s [NPIX_S];
    logic [7:0]    mem_l [NPIX_L];
    logic [AW-1:0] max_addr_s = '0;
    logic [AW-1:0] max_addr_l = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    color_detect_if #(.AW(AW)) bus_s ();
    color_detect_if #(.AW(AW)) bus_l ();

    color_detect #(.AW(AW), .NPIX(NPIX_S), .MIN_CNT(MIN_S)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s.slave)
    );

    color_detect #(.AW(AW), .NPIX(NPIX_L), .MIN_CNT(MIN_L)) dut_l (
        .clk (clk),
        .rst (rst_l),
        .bus (bus_l.slave)
    );

    // Synchronous-read frame buffers.
    always @(posedge clk) begin
        bus_s.rd_data <= (bus_s.rd_addr < AW'(NPIX_S)) ? mem_s[bus_s.rd_addr[3:0]] : 8'hxx;
        bus_l.rd_data <= (bus_l.rd_addr < AW'(NPIX_L)) ? mem_l[bus_l.rd_addr] : 8'hxx;
    end

    always @(negedge clk) begin
        if (bus_s.rd_addr > max_addr_s) max_addr_s <= bus_s.rd_addr;
        if (bus_l.rd_addr > max_addr_l) max_addr_l <= bus_l.rd_addr;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: tally the classes, then pick the first class
    // (red, green, blue) holding the maximum tally.
    function automatic exp_t model(input pix_q_t pix, input int min_cnt);
        exp_t e;
        int   cnt [3];
        int   r, g, b, best, pick;
        cnt = '{0, 0, 0};
        foreach (pix[i]) begin
            r = int'(pix[i]) / 32;
            g = (int'(pix[i]) / 4) % 8;
            b = int'(pix[i]) % 4;
            if (r >= 5 && g <= 2 && b <= 1)      cnt[0]++;
            else if (g >= 5 && r <= 2 && b <= 1) cnt[1]++;
            else if (b == 3 && r <= 2 && g <= 2) cnt[2]++;
        end
        best = cnt[0];
        if (cnt[1] > best) best = cnt[1];
        if (cnt[2] > best) best = cnt[2];
        pick = (cnt[0] == best) ? 1 : (cnt[1] == best) ? 2 : 3;
        e.r        = cnt[0];
        e.g        = cnt[1];
        e.b        = cnt[2];
        e.color    = (best < min_cnt) ? 2'd0 : 2'(pick);
        e.done_cyc = 0;
        return e;
    endfunction

    function automatic logic [7:0] rand_pix();
        logic [2:0] r, g;
        logic [1:0] b;
        case ($urandom_range(0, 4))
            0: begin r = 3'($urandom_range(5, 7)); g = 3'($urandom_range(0, 2)); b = 2'($urandom_range(0, 1)); end
            1: begin r = 3'($urandom_range(0, 2)); g = 3'($urandom_range(5, 7)); b = 2'($urandom_range(0, 1)); end
            2: begin r = 3'($urandom_range(0, 2)); g = 3'($urandom_range(0, 2)); b = 2'd3; end
            default: return 8'($urandom);
        endcase
        return {r, g, b};
    endfunction

    function automatic exp_t expect_s();
        pix_q_t q;
        foreach (mem_s[i]) q.push_back(mem_s[i]);
        return model(q, MIN_S);
    endfunction

    function automatic exp_t expect_l();
        pix_q_t q;
        foreach (mem_l[i]) q.push_back(mem_l[i]);
        return model(q, MIN_L);
    endfunction

    // Called on a negedge with the DUT idle; start is taken at the next edge.
    task automatic start_scan(input bit big);
        exp_t e;
        if (big) begin
            e = expect_l();
            e.done_cyc = cyc + 1 + NPIX_L + 2;
            sb_l.push_back(e);
            bus_l.start = 1'b1;
            @(negedge clk);
            bus_l.start = 1'b0;
            check("l_busy_after_start", bus_l.busy, 1);
        end else begin
            e = expect_s();
            e.done_cyc = cyc + 1 + NPIX_S + 2;
            sb_s.push_back(e);
            bus_s.start = 1'b1;
            @(negedge clk);
            bus_s.start = 1'b0;
            check("s_busy_after_start", bus_s.busy, 1);
        end
    endtask

    task automatic wait_scan(input bit big, input int budget);
        int n = 0;
        if (big) begin
            while ((sb_l.size() != 0 || bus_l.busy !== 1'b0) && n < budget) begin
                @(negedge clk);
                n++;
            end
        end else begin
            while ((sb_s.size() != 0 || bus_s.busy !== 1'b0) && n < budget) begin
                @(negedge clk);
                n++;
            end
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_timeout: waited %0d cycles, required done within %0d", big ? "l" : "s", n, budget);
            if (big) sb_l.delete(); else sb_s.delete();
        end
    endtask

    // Monitors: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_s === 1'b1 && bus_s.done === 1'b1) begin
            if (sb_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                mon_e_s = sb_s.pop_front();
                check("s_done_cycle", 64'(cyc), 64'(mon_e_s.done_cyc));
                check("s_cnt_r", bus_s.cnt_r, 64'(mon_e_s.r));
                check("s_cnt_g", bus_s.cnt_g, 64'(mon_e_s.g));
                check("s_cnt_b", bus_s.cnt_b, 64'(mon_e_s.b));
                check("s_color", bus_s.color, mon_e_s.color);
                check("s_busy_at_done", bus_s.busy, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_l === 1'b1 && bus_l.done === 1'b1) begin
            if (sb_l.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL l_unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                mon_e_l = sb_l.pop_front();
                check("l_done_cycle", 64'(cyc), 64'(mon_e_l.done_cyc));
                check("l_cnt_r", bus_l.cnt_r, 64'(mon_e_l.r));
                check("l_cnt_g", bus_l.cnt_g, 64'(mon_e_l.g));
                check("l_cnt_b", bus_l.cnt_b, 64'(mon_e_l.b));
                check("l_color", bus_l.color, mon_e_l.color);
                check("l_busy_at_done", bus_l.busy, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_s       = 1'b0;
        rst_l       = 1'b0;
        bus_s.start = 1'b0;
        bus_l.start = 1'b0;
        foreach (mem_s[i]) mem_s[i] = 8'h00;
        foreach (mem_l[i]) mem_l[i] = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_busy",  bus_s.busy, 0);
        check("rst_done",  bus_s.done, 0);
        check("rst_addr",  bus_s.rd_addr, 0);
        check("rst_color", bus_s.color, 0);
        check("rst_cnt_r", bus_s.cnt_r, 0);
        check("rst_l_busy", bus_l.busy, 0);
        rst_s = 1'b1;
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        // All-red frame.
        foreach (mem_s[i]) mem_s[i] = 8'hE0;
        start_scan(1'b0);
        wait_scan(1'b0, NPIX_S + 10);
        check("red_cnt_r", bus_s.cnt_r, 16);
        check("red_color", bus_s.color, 2'b01);

        // Reset mid-scan at edge 7; outputs clear without waiting for a clock.
        start_scan(1'b0);
        repeat (6) @(negedge clk);
        rst_s = 1'b0;
        #1;
        sb_s.delete();
        check("midrst_busy",  bus_s.busy, 0);
        check("midrst_done",  bus_s.done, 0);
        check("midrst_addr",  bus_s.rd_addr, 0);
        check("midrst_color", bus_s.color, 0);
        check("midrst_cnt_r", bus_s.cnt_r, 0);
        @(negedge clk);
        rst_s = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("postrst_busy", bus_s.busy, 0);
        end

        // Mixed frame: green and blue tie at 5, red 4, two others.
        mem_s = '{8'h1C, 8'h03, 8'hE0, 8'h1C, 8'h03, 8'hE0, 8'hFF, 8'h1C,
                  8'h03, 8'hE0, 8'h1C, 8'h03, 8'hFF, 8'hE0, 8'h1C, 8'h03};
        start_scan(1'b0);
        wait_scan(1'b0, NPIX_S + 10);
        check("mixed_cnt_g", bus_s.cnt_g, 5);
        check("mixed_cnt_b", bus_s.cnt_b, 5);
        check("mixed_cnt_r", bus_s.cnt_r, 4);
        check("mixed_color", bus_s.color, 2'b10);

        // Boundary pixels: only the first and last addresses are blue.
        foreach (mem_s[i]) mem_s[i] = 8'h00;
        mem_s[0]          = 8'h03;
        mem_s[NPIX_S - 1] = 8'h03;
        start_scan(1'b0);
        wait_scan(1'b0, NPIX_S + 10);
        check("edge_cnt_b", bus_s.cnt_b, 2);
        check("edge_color", bus_s.color, 2'b11);

        // Single red pixel is below MIN_CNT.
        foreach (mem_s[i]) mem_s[i] = 8'h00;
        mem_s[7] = 8'hE0;
        start_scan(1'b0);
        wait_scan(1'b0, NPIX_S + 10);
        check("thr_cnt_r", bus_s.cnt_r, 1);
        check("thr_color", bus_s.color, 2'b00);

        // Start pulsed at edge 5 of a scan is ignored.
        foreach (mem_s[i]) mem_s[i] = rand_pix();
        start_scan(1'b0);
        repeat (4) @(negedge clk);
        bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
        wait_scan(1'b0, 2 * NPIX_S + 10);
        repeat (3) begin
            @(negedge clk);
            check("ignored_start_busy", bus_s.busy, 0);
        end

        // Start held across done: second scan accepted at edge NPIX+3.
        foreach (mem_s[i]) mem_s[i] = rand_pix();
        e = expect_s();
        e.done_cyc = cyc + 1 + NPIX_S + 2;
        sb_s.push_back(e);
        e.done_cyc = e.done_cyc + NPIX_S + 3;
        sb_s.push_back(e);
        bus_s.start = 1'b1;
        repeat (NPIX_S + 4) @(negedge clk);
        bus_s.start = 1'b0;
        wait_scan(1'b0, 2 * NPIX_S + 10);

        // Random frames.
        for (int it = 0; it < 25; it++) begin
            foreach (mem_s[i]) mem_s[i] = rand_pix();
            start_scan(1'b0);
            wait_scan(1'b0, NPIX_S + 10);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Full frame: 63 red pixels scattered over a black frame.
        for (int i = 0; i < 63; i++)
            mem_l[i * 300 + int'($urandom_range(0, 299))] = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
        start_scan(1'b1);
        wait_scan(1'b1, NPIX_L + 20);
        check("full63_cnt_r", bus_l.cnt_r, 63);
        check("full63_color", bus_l.color, 2'b00);
        check("full63_last_addr", bus_l.rd_addr, NPIX_L - 1);

        // One more red pixel reaches MIN_CNT.
        mem_l[19000] = 8'hE0;
        start_scan(1'b1);
        wait_scan(1'b1, NPIX_L + 20);
        check("full64_cnt_r", bus_l.cnt_r, 64);
        check("full64_color", bus_l.color, 2'b01);

        repeat (3) @(negedge clk);
        check("s_max_addr", max_addr_s, NPIX_S - 1);
        check("l_max_addr", max_addr_l, NPIX_L - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
